uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Multi-requester UART transmit scheduler for the 50 MHz fabric. NREQ byte sources share one serial TX line.
//  Round-robin arbitration picks one requester per frame and latches its byte.
//  An internal baud counter serialises the frame: start, 8 data bits LSB-first, optional parity, stop.
//  Sits between on-chip producers and the TX pin; bsy feeds existing UART control logic.
// PARAMETERS
//  CLK_HZ   50000000  input clock frequency, Hz
//  BAUD     9600      line rate; BIT_CYC = CLK_HZ/BAUD (truncating), must be >= 2
//  NREQ     4         number of requesters, 2..8
// PORTS
//  clk_in   in   1          system clock, single clock domain
//  rst      in   1          reset, asynchronous, active-low
//  req      in   NREQ       per-requester byte-valid; held until matching gnt bit
//  data     in   NREQ*8     byte for requester i at data[8*i+:8]; stable while req[i]=1
//  gnt      out  NREQ       one-hot, one-cycle pulse: requester's byte accepted
//  gnt_id   out  $clog2(NREQ)  index of current/last winner
//  tx       out  1          serial line, idle high
//  bsy      out  1          high while a frame is on the line
// BEHAVIOUR
//  - Reset (rst=0, async): tx=1, bsy=0, gnt=0, gnt_id=0, state IDLE, bit counter 0.
//    The RR pointer is set so that req[0] has highest priority.
//  - Reset asserted mid-frame aborts the frame immediately. No partial stop bit. The byte is lost; no re-grant.
//  - States: IDLE -> START -> DATA(8 bits) -> [PARITY] -> STOP -> IDLE|START.
//  - Each of START, DATA-bit, PARITY and STOP lasts exactly BIT_CYC clocks.
//  - Baud counter counts 0..BIT_CYC-1. It is reloaded at every state entry, so there is no phase carry-over.
//  - Arbitration is evaluated in IDLE, and in the last STOP cycle.
//    Search order is gnt_id+1, gnt_id+2, ... wrapping modulo NREQ. The first set req wins.
//  - Grant edge (all updates on the same clock edge):
//    - gnt[w]=1 for one cycle.
//    - gnt_id=w.
//    - data[8*w+:8] latched into the shift register.
//    - State -> START, tx=0, bsy=1.
//  - Latency: req sampled high in IDLE at edge k gives gnt and tx low after edge k (1 clock).
//  - Back-to-back: if any req is high in the last STOP cycle, the next START follows with zero idle clocks.
//    bsy stays 1.
//  - If no req is high at end of STOP: state -> IDLE, bsy=0, tx=1.
//  - req dropped before grant is ignored; no state change. req[w] may fall in the gnt cycle.
//  - Data shifting: tx = shift_reg[0] during each DATA bit; shift right at each bit boundary.
//    A 3-bit index counts 0..7; it saturates and is cleared on START.
//  - Frame length: 10*BIT_CYC clocks, or 11*BIT_CYC with parity.
// CONFIGURATION
//  - UART_PARITY_EN defined: PARITY state inserted after DATA bit 7.
//    tx = ^byte (even parity: total ones incl. parity even). Parity is computed from the latched byte.
//  - UART_PARITY_EN undefined: no PARITY state, no parity logic; DATA bit 7 -> STOP.
// STRUCTURE
//  - Package uart_pkg:
//    - typedef enum logic [2:0] tx_state_t {IDLE,START,DATA,PARITY,STOP}.
//    - localparam CLK_HZ_DEFAULT=50000000.
//    - function bit_cyc(clk_hz, baud).
//  - Sub-module uart_rr_arb #(NREQ): combinational round-robin pick.
//    Inputs: req, last id. Outputs: any, win id.
//  - The top level owns the FSM, baud counter, shift register and pointer update.
// TESTING (CLK_HZ=50e6, BAUD=115200 -> BIT_CYC=434, NREQ=4)
//  1. Single: req=4'b0001, data[7:0]=8'h55.
//     -> gnt=0001 for 1 clk; tx low 434 clks, then 1,0,1,0,1,0,1,0 at 434 each, then high 434.
//     -> bsy high exactly 4340 clks.
//  2. Round-robin: req=4'b1111 held (each re-raised after gnt). -> gnt_id sequence 0,1,2,3,0.
//     Consecutive START edges are 4340 clks apart, with no idle gap.
//  3. Priority after a win: last winner 0, then req=4'b0101. -> requester 2 granted before 0.
//  4. Reset abort: rst low during DATA bit 4. -> tx=1, bsy=0, gnt=0 asynchronously.
//     After release with req=4'b1000: gnt_id=3, fresh full frame.
//  5. Parity (UART_PARITY_EN): data 8'h07 -> parity bit 1, frame 4774 clks.
//     data 8'h03 -> parity bit 0. Without macro: frame 4340 clks.
//  6. Ignored request: req[1] pulsed 1 clk while bsy=1 and dropped before STOP end.
//     -> no gnt[1]; return to IDLE, tx=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and helpers for the multi-requester UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int CLK_HZ_DEFAULT = 50000000;

  function automatic int bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] byte_v);
    return ^byte_v;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: combinational round-robin pick; the first set req after last_id (wrapping) wins.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_id,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] win_id
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] idx_s;

  // Scan from the farthest candidate to the nearest so the nearest set request is left standing.
  always_comb begin
    any    = 1'b0;
    win_id = last_id;
    idx_s  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx_s = IDW'((int'(last_id) + i) % NREQ);
      if (req[idx_s]) begin
        any    = 1'b1;
        win_id = idx_s;
      end else begin
        any    = any;
        win_id = win_id;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: NREQ byte sources share one UART TX line, one round-robin grant per frame.
// Build option: define UART_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int BAUD   = 9600,
  parameter int NREQ   = 4
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*8-1:0]       data,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    tx,
  output logic                    bsy
);

  localparam int BIT_CYC = bit_cyc(CLK_HZ, BAUD);
  localparam int BW      = $clog2(BIT_CYC);
  localparam int IDW     = $clog2(NREQ);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYC - 1);

  tx_state_t       state_r, state_n;
  logic [BW-1:0]   baud_r, baud_n;
  logic [2:0]      bit_r, bit_n;
  logic [7:0]      shift_r, shift_n;
  logic [7:0]      sel_byte_s;
  logic [IDW-1:0]  ptr_r, ptr_n;
  logic [IDW-1:0]  gnt_id_r, gnt_id_n;
  logic [IDW-1:0]  win_s;
  logic [NREQ-1:0] gnt_r, gnt_n;
  logic            tx_r, tx_n;
  logic            bsy_r, bsy_n;
  logic            any_s, baud_last_s, grant_s;
`ifdef UART_PARITY_EN
  logic            par_r, par_n;
`endif

  uart_rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .last_id(ptr_r),
    .any    (any_s),
    .win_id (win_s)
  );

  assign baud_last_s = (baud_r == BAUD_LAST);

  // Byte of the current arbitration winner.
  always_comb begin
    sel_byte_s = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (win_s == IDW'(i)) begin
        sel_byte_s = data[8*i +: 8];
      end else begin
        sel_byte_s = sel_byte_s;
      end
    end
  end

  // Frame sequencing; the grant path overrides whatever IDLE or the last STOP cycle decided.
  always_comb begin
    state_n  = state_r;
    baud_n   = baud_last_s ? '0 : baud_r + BW'(1);
    bit_n    = bit_r;
    shift_n  = shift_r;
    tx_n     = tx_r;
    bsy_n    = bsy_r;
    gnt_n    = '0;
    gnt_id_n = gnt_id_r;
    ptr_n    = ptr_r;
    grant_s  = 1'b0;
`ifdef UART_PARITY_EN
    par_n    = par_r;
`endif
    case (state_r)
      IDLE: begin
        baud_n  = '0;
        tx_n    = 1'b1;
        bsy_n   = 1'b0;
        grant_s = any_s;
      end
      START: begin
        if (baud_last_s) begin
          state_n = DATA;
          tx_n    = shift_r[0];
          shift_n = {1'b0, shift_r[7:1]};
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (baud_last_s) begin
          if (bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = PARITY;
            tx_n    = par_r;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_r + 3'd1;
            tx_n    = shift_r[0];
            shift_n = {1'b0, shift_r[7:1]};
          end
        end else begin
          state_n = DATA;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_last_s) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          state_n = PARITY;
        end
      end
`endif
      STOP: begin
        if (baud_last_s) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          bsy_n   = 1'b0;
          grant_s = any_s;
        end else begin
          state_n = STOP;
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
        bsy_n   = 1'b0;
      end
    endcase
    if (grant_s) begin
      state_n       = START;
      baud_n        = '0;
      bit_n         = 3'd0;
      shift_n       = sel_byte_s;
      tx_n          = 1'b0;
      bsy_n         = 1'b1;
      gnt_n[win_s]  = 1'b1;
      gnt_id_n      = win_s;
      ptr_n         = win_s;
`ifdef UART_PARITY_EN
      par_n         = even_parity(sel_byte_s);
`endif
    end else begin
      gnt_n = '0;
    end
  end

  // State and output registers; reset leaves req[0] at top priority while gnt_id reads 0.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      baud_r   <= '0;
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      ptr_r    <= IDW'(NREQ - 1);
      gnt_id_r <= '0;
      gnt_r    <= '0;
      tx_r     <= 1'b1;
      bsy_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      baud_r   <= baud_n;
      bit_r    <= bit_n;
      shift_r  <= shift_n;
      ptr_r    <= ptr_n;
      gnt_id_r <= gnt_id_n;
      gnt_r    <= gnt_n;
      tx_r     <= tx_n;
      bsy_r    <= bsy_n;
    end
  end

`ifdef UART_PARITY_EN
  // Parity of the accepted byte, held for the whole frame.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      par_r <= 1'b0;
    end else begin
      par_r <= par_n;
    end
  end
`endif

  assign gnt    = gnt_r;
  assign gnt_id = gnt_id_r;
  assign tx     = tx_r;
  assign bsy    = bsy_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized scoreboard bench; the stimulus predicts grant order and frames,
// an independent monitor checks every frame on the line cycle by cycle.
module tb_uart_tx_sched;

  localparam int NREQ    = 4;
  localparam int BIT_CYC = 50000000 / 115200;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BIT_CYC;

  typedef struct {
    int         id;
    logic [7:0] byte_v;
    bit         b2b;
  } exp_t;

  logic        clk_in;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        tx;
  logic        bsy;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  int         model_last;
  logic [7:0] bytes_v[NREQ];

  uart_tx_sched #(
    .CLK_HZ(50000000),
    .BAUD  (115200),
    .NREQ  (NREQ)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .gnt_id(gnt_id),
    .tx    (tx),
    .bsy   (bsy)
  );

  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  task automatic chk(input string name, input bit ok, input int act, input int expv);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Called at the negedge of frame cycle 0; returns at the negedge of cycle FRAME.
  task automatic check_frame(input exp_t e);
    logic [NBITS-1:0] bits_v;
    int err_c = -1;
    bit bsy_ok = 1'b1;
    bit gnt_ok = 1'b1;
`ifdef UART_PARITY_EN
    bits_v = {1'b1, ^e.byte_v, e.byte_v, 1'b0};
`else
    bits_v = {1'b1, e.byte_v, 1'b0};
`endif
    chk("gnt_onehot", gnt === (4'b0001 << e.id), int'(gnt), 1 << e.id);
    chk("gnt_id", int'(gnt_id) == e.id, int'(gnt_id), e.id);
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk_in);
      if (tx !== bits_v[c / BIT_CYC] && err_c < 0) err_c = c;
      if (bsy !== 1'b1) bsy_ok = 1'b0;
      if (c > 0 && gnt !== 4'b0000) gnt_ok = 1'b0;
    end
    chk("frame_bits_first_bad_cycle", err_c < 0, err_c, -1);
    chk("bsy_whole_frame", bsy_ok, int'(bsy_ok), 1);
    chk("gnt_single_pulse", gnt_ok, int'(gnt_ok), 1);
    @(negedge clk_in);
    if (e.b2b) begin
      chk("b2b_start", gnt !== 4'b0000 && bsy === 1'b1, int'(gnt), 1);
    end else begin
      chk("idle_after_frame", bsy === 1'b0 && tx === 1'b1, int'({bsy, tx}), 1);
    end
  endtask

  // Monitor: pops an expectation for every grant and follows the frame on the line.
  initial begin : monitor
    exp_t e;
    bit   skip_wait;
    skip_wait = 1'b0;
    forever begin
      if (!skip_wait) @(negedge clk_in);
      skip_wait = 1'b0;
      if (mon_en && gnt !== 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_gnt", 1'b0, int'(gnt), 0);
        end else begin
          e = sb.pop_front();
          check_frame(e);
          skip_wait = 1'b1;
        end
      end
    end
  end

  // Raise every requester in mask, predict the grant order, drop each req on its grant.
  task automatic run_batch(input logic [3:0] mask, input int pulse_at);
    int   order[$];
    exp_t e;
    int   cyc = 0;
    bit   done = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      int k;
      k = (model_last + i) % NREQ;
      if (mask[k]) order.push_back(k);
    end
    for (int j = 0; j < order.size(); j++) begin
      e.id     = order[j];
      e.byte_v = bytes_v[order[j]];
      e.b2b    = (j < order.size() - 1);
      sb.push_back(e);
    end
    model_last = order[order.size() - 1];
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) data[8*i +: 8] = bytes_v[i];
    end
    req = mask;
    while (!done && cyc < (order.size() + 1) * FRAME + 100) begin
      @(negedge clk_in);
      cyc++;
      req = req & ~gnt;
      if (pulse_at > 0 && cyc == pulse_at) req[1] = 1'b1;
      else if (pulse_at > 0 && cyc == pulse_at + 1) req[1] = 1'b0;
      done = (sb.size() == 0) && (bsy === 1'b0) && (req == 4'b0000);
    end
    chk("batch_complete", done, cyc, order.size() * FRAME);
    repeat (5) @(negedge clk_in);
  endtask

  // Hard stop in case something above fails to terminate.
  initial begin : watchdog
    repeat (99000) @(posedge clk_in);
    $display("FAIL watchdog: got no finish expected finish within 99000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cyc;
    rst  = 1'b1;
    req  = 4'b0000;
    data = 32'h0000_0000;
    #5 rst = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset_tx", tx === 1'b1, int'(tx), 1);
    chk("reset_bsy", bsy === 1'b0, int'(bsy), 0);
    chk("reset_gnt", gnt === 4'b0000, int'(gnt), 0);
    chk("reset_gnt_id", gnt_id === 2'd0, int'(gnt_id), 0);
    rst = 1'b1;
    model_last = NREQ - 1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk_in);

    // All four from reset: 0,1,2,3 back to back; parity samples 07 and 03.
    bytes_v[0] = 8'h07;
    bytes_v[1] = 8'h03;
    bytes_v[2] = 8'($urandom);
    bytes_v[3] = 8'($urandom);
    run_batch(4'b1111, 0);

    // Single 0x55 from requester 0 after 3 won.
    bytes_v[0] = 8'h55;
    run_batch(4'b0001, 0);

    // Last winner 0: requester 2 must go before 0.
    bytes_v[0] = 8'($urandom);
    bytes_v[2] = 8'($urandom);
    run_batch(4'b0101, 0);

    // Requester 1 pulsed for one clock mid-frame must never be granted.
    bytes_v[0] = 8'($urandom);
    run_batch(4'b0001, 1000);

    // Reset in the middle of DATA bit 4 aborts the frame at once.
    mon_en = 1'b0;
    data[7:0] = 8'hA5;
    req = 4'b0001;
    cyc = 0;
    while (gnt === 4'b0000 && cyc < 50) begin
      @(negedge clk_in);
      cyc++;
    end
    chk("abort_pre_gnt", gnt === 4'b0001, int'(gnt), 1);
    req = 4'b0000;
    repeat (5 * BIT_CYC + 200) @(negedge clk_in);
    #3 rst = 1'b0;
    #1;
    chk("abort_tx", tx === 1'b1, int'(tx), 1);
    chk("abort_bsy", bsy === 1'b0, int'(bsy), 0);
    chk("abort_gnt", gnt === 4'b0000, int'(gnt), 0);
    chk("abort_gnt_id", gnt_id === 2'd0, int'(gnt_id), 0);
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    model_last = NREQ - 1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk_in);
    bytes_v[3] = 8'($urandom);
    run_batch(4'b1000, 0);

    // Random mask and bytes.
    for (int i = 0; i < NREQ; i++) bytes_v[i] = 8'($urandom);
    run_batch(4'($urandom_range(1, 15)), 0);

    chk("scoreboard_empty", sb.size() == 0, sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
